// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing for the 5-stage core: load-use stalls, redirect squashes,
// halt drain/freeze, and a saturating load-use stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned NDRAIN = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_halt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [STALL_W-1:0] stall_nxt;
    logic               load_use_c;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use_c = ex_memread && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // State, drain counter and stall counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            stall_cycles <= stall_nxt;
        end
    end

    // Next-state: redirect beats load-use beats halt while running
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_nxt = stall_cycles;
        case (state)
            RUN: begin
                if (ex_redirect) begin
                    state_nxt = RUN;
                end else if (load_use_c) begin
                    if (stall_cycles != {STALL_W{1'b1}}) begin
                        stall_nxt = stall_cycles + STALL_W'(1);
                    end
                end else if (id_halt) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(NDRAIN);
                end
            end
            DRAIN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Zero-latency enable/flush decode
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        case (state)
            RUN: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use_c || id_halt) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            HALTED: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected output vectors are queued
// as each cycle's stimulus is applied and popped when the outputs are sampled.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned NDRAIN = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_halt;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
    logic [15:0] stall_cycles;

    typedef struct packed {
        logic        pc_write;
        logic        ifid_write;
        logic        ifid_flush;
        logic        idex_flush;
        logic        halted;
        logic [15:0] stall_cycles;
    } out_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       halt;
        logic       memread;
        logic [4:0] rd;
        logic       redirect;
    } in_t;

    typedef enum int {K_RUN, K_FREEZE, K_REDIR, K_HALT} kind_t;

    out_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.NDRAIN(NDRAIN)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_halt      (id_halt),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    function automatic in_t mk_in(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic halt, input logic memread,
                                  input logic [4:0] rd, input logic redirect);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.halt = halt;
        v.memread = memread; v.rd = rd; v.redirect = redirect;
        return v;
    endfunction

    // Expected output vector: {pc_write, ifid_write, ifid_flush, idex_flush, halted}
    function automatic out_t exp_of(input kind_t k, input logic [15:0] s);
        out_t o;
        case (k)
            K_RUN:    {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_flush, o.halted} = 5'b11000;
            K_FREEZE: {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_flush, o.halted} = 5'b00010;
            K_REDIR:  {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_flush, o.halted} = 5'b11110;
            default:  {o.pc_write, o.ifid_write, o.ifid_flush, o.idex_flush, o.halted} = 5'b00011;
        endcase
        o.stall_cycles = s;
        return o;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.pc_write = pc_write; o.ifid_write = ifid_write; o.ifid_flush = ifid_flush;
        o.idex_flush = idex_flush; o.halted = halted; o.stall_cycles = stall_cycles;
        return o;
    endfunction

    task automatic set_inputs(input in_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_halt = v.halt;
        ex_memread = v.memread; ex_rd = v.rd; ex_redirect = v.redirect;
    endtask

    // One cycle: inputs 1 after the rising edge, returns 4 after it (sample point)
    task automatic drive(input in_t v);
        @(posedge clk);
        #1;
        set_inputs(v);
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        set_inputs('0);
        #4;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        out_t e, g;
        reset_n = 1'b0;
        set_inputs('0);
        #3;
        sb.push_back(exp_of(K_RUN, 16'd0));
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL reset_idle: got %h required %h", g, e);
        end
        set_inputs(mk_in(5'd4, 5'd1, 1'b1, 1'b1, 5'd4, 1'b0));
        sb.push_back(exp_of(K_FREEZE, 16'd0));
        #5;
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL reset_held_loaduse: got %h required %h", g, e);
        end
        set_inputs('0);
        #4;
        reset_n = 1'b1;
        sb.push_back(exp_of(K_RUN, 16'd0));
        drive('0);
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL reset_release: got %h required %h", g, e);
        end
    endtask

    task automatic test_load_use();
        in_t         vin[7];
        kind_t       k[7];
        logic [15:0] s[7];
        out_t        e, g;
        do_reset();
        vin = '{mk_in(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0),
                '0,
                mk_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0),
                mk_in(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b0),
                mk_in(5'd7, 5'd2, 1'b0, 1'b0, 5'd7, 1'b0),
                mk_in(5'd8, 5'd9, 1'b0, 1'b1, 5'd7, 1'b0),
                '0};
        k   = '{K_FREEZE, K_RUN, K_RUN, K_FREEZE, K_RUN, K_RUN, K_RUN};
        s   = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2};
        for (int i = 0; i < 7; i++) begin
            sb.push_back(exp_of(k[i], s[i]));
            drive(vin[i]);
            e = sb.pop_front(); g = observe(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL load_use[%0d]: got %h required %h", i, g, e);
            end
        end
    endtask

    task automatic test_redirect();
        in_t         vin[5];
        kind_t       k[5];
        logic [15:0] s[5];
        out_t        e, g;
        do_reset();
        vin = '{mk_in(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0),
                mk_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1),
                '0,
                mk_in(5'd9, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1),
                '0};
        k   = '{K_FREEZE, K_REDIR, K_RUN, K_REDIR, K_RUN};
        s   = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exp_of(k[i], s[i]));
            drive(vin[i]);
            e = sb.pop_front(); g = observe(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL redirect[%0d]: got %h required %h", i, g, e);
            end
        end
    endtask

    // Halt at index 2 (cycle T): drain T+1..T+3, halted from T+4, inputs ignored
    task automatic test_halt();
        in_t         vin[10];
        kind_t       k[10];
        out_t        e, g;
        do_reset();
        vin = '{'0,
                '0,
                mk_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0),
                '0,
                mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1),
                mk_in(5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0),
                '0,
                mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1),
                mk_in(5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b0),
                '0};
        k   = '{K_RUN, K_RUN, K_FREEZE, K_FREEZE, K_FREEZE, K_FREEZE,
                K_HALT, K_HALT, K_HALT, K_HALT};
        for (int i = 0; i < 10; i++) begin
            sb.push_back(exp_of(k[i], 16'd0));
            drive(vin[i]);
            e = sb.pop_front(); g = observe(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL halt[%0d]: got %h required %h", i, g, e);
            end
        end
    endtask

    task automatic test_halt_blocked();
        in_t         vin[7];
        kind_t       k[7];
        logic [15:0] s[7];
        out_t        e, g;
        do_reset();
        vin = '{mk_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd2, 1'b0),
                mk_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0),
                '0,
                '0,
                '0,
                '0,
                mk_in(5'd3, 5'd3, 1'b0, 1'b1, 5'd3, 1'b0)};
        k   = '{K_FREEZE, K_FREEZE, K_FREEZE, K_FREEZE, K_FREEZE, K_HALT, K_HALT};
        s   = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
        for (int i = 0; i < 7; i++) begin
            sb.push_back(exp_of(k[i], s[i]));
            drive(vin[i]);
            e = sb.pop_front(); g = observe(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL halt_blocked[%0d]: got %h required %h", i, g, e);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        out_t e, g;
        do_reset();
        sb.push_back(exp_of(K_FREEZE, 16'd0));
        drive(mk_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0));
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL mid_drain_stall: got %h required %h", g, e);
        end
        sb.push_back(exp_of(K_FREEZE, 16'd1));
        drive(mk_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0));
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL mid_drain_halt: got %h required %h", g, e);
        end
        sb.push_back(exp_of(K_FREEZE, 16'd1));
        drive('0);
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL mid_drain_draining: got %h required %h", g, e);
        end
        #1;
        reset_n = 1'b0;
        sb.push_back(exp_of(K_RUN, 16'd0));
        #1;
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL mid_drain_async_reset: got %h required %h", g, e);
        end
        #4;
        reset_n = 1'b1;
        sb.push_back(exp_of(K_FREEZE, 16'd0));
        drive(mk_in(5'd11, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0));
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL mid_drain_resume_stall: got %h required %h", g, e);
        end
        sb.push_back(exp_of(K_RUN, 16'd1));
        drive('0);
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL mid_drain_resume_run: got %h required %h", g, e);
        end
    endtask

    task automatic test_saturation();
        out_t e, g;
        do_reset();
        sb.push_back(exp_of(K_FREEZE, 16'd0));
        drive(mk_in(5'd12, 5'd13, 1'b0, 1'b1, 5'd13, 1'b0));
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL sat_first: got %h required %h", g, e);
        end
        sb.push_back(exp_of(K_FREEZE, 16'hFFFE));
        repeat (65534) @(posedge clk);
        #4;
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL sat_fffe: got %h required %h", g, e);
        end
        sb.push_back(exp_of(K_FREEZE, 16'hFFFF));
        @(posedge clk);
        #4;
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL sat_ffff: got %h required %h", g, e);
        end
        sb.push_back(exp_of(K_FREEZE, 16'hFFFF));
        repeat (4465) @(posedge clk);
        #4;
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL sat_hold: got %h required %h", g, e);
        end
        sb.push_back(exp_of(K_RUN, 16'hFFFF));
        drive('0);
        e = sb.pop_front(); g = observe(); vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL sat_release: got %h required %h", g, e);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_halt();
        test_halt_blocked();
        test_reset_mid_drain();
        test_saturation();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
